// File: rtl/edge_hyst.sv
// Double-threshold hysteresis over a 3x3 window; read, classify, write as a 3-stage pipeline.
// Window entry (r,c) sits at rd_data_flat[(r*WIN_WD+c)*PXL_BITS +: PXL_BITS]. EDGE_HYST_CNT_EN builds edge_cnt.
module edge_hyst #(
  parameter int unsigned IMG_WD     = 4,
  parameter int unsigned IMG_HT     = 4,
  parameter int unsigned COORD_BITS = 2,
  parameter int unsigned WIN_WD     = 3,
  parameter int unsigned WIN_HT     = 3,
  parameter int unsigned PXL_BITS   = 8,
  parameter int unsigned CNT_BITS   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 run,
  output logic                                 done,
  input  logic [PXL_BITS-2:0]                  thr_lo,
  input  logic [PXL_BITS-2:0]                  thr_hi,
  output logic                                 rd_en,
  output logic [COORD_BITS-1:0]                rd_x,
  output logic [COORD_BITS-1:0]                rd_y,
  input  logic [WIN_HT*WIN_WD*PXL_BITS-1:0]    rd_data_flat,
  output logic                                 wr_en,
  output logic [COORD_BITS-1:0]                wr_x,
  output logic [COORD_BITS-1:0]                wr_y,
  output logic [PXL_BITS-1:0]                  wr_data_pxl,
  output logic [CNT_BITS-1:0]                  edge_cnt
);

  localparam int unsigned MAG_BITS = PXL_BITS - 1;
  localparam int unsigned NWIN     = WIN_WD * WIN_HT;
  localparam int unsigned CENTRE   = (WIN_HT / 2) * WIN_WD + WIN_WD / 2;
  localparam logic [MAG_BITS-1:0]   MAG_MAX = '1;
  localparam logic [COORD_BITS-1:0] X_LAST  = COORD_BITS'(IMG_WD - 1);
  localparam logic [COORD_BITS-1:0] Y_LAST  = COORD_BITS'(IMG_HT - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e state_q, state_d;
  logic [COORD_BITS-1:0] cur_x_q, cur_y_q;
  logic [MAG_BITS-1:0]   lo_q, hi_q, lo_e, c_mag;
  logic                  v1_q, nb_strong, is_edge, last_pix;
  logic [COORD_BITS-1:0] x1_q, y1_q, wr_x_q, wr_y_q;
  logic                  wr_en_q;
  logic [PXL_BITS-1:0]   wr_data_q;

  // Two's-complement magnitude; the most-negative code saturates to MAG_MAX.
  function automatic logic [MAG_BITS-1:0] mag(input logic [PXL_BITS-1:0] v);
    logic [PXL_BITS-1:0] a;
    a = v[PXL_BITS-1] ? (~v + 1'b1) : v;
    return a[PXL_BITS-1] ? MAG_MAX : a[MAG_BITS-1:0];
  endfunction

  assign last_pix = (cur_x_q == X_LAST) && (cur_y_q == Y_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run) state_d = StScan;
      StScan:  if (run && last_pix) state_d = StDrain;
      StDrain: if (!v1_q) state_d = StDone;
      StDone:  if (!run) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_en = (state_q == StScan) && run;
    done  = (state_q == StDone);
  end

  assign rd_x = cur_x_q;
  assign rd_y = cur_y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      if (state_q == StIdle && run) begin
        lo_q <= thr_lo;
        hi_q <= thr_hi;
      end
      if (rd_en) begin
        if (cur_x_q == X_LAST) begin
          cur_x_q <= '0;
          cur_y_q <= (cur_y_q == Y_LAST) ? '0 : cur_y_q + 1'b1;
        end else begin
          cur_x_q <= cur_x_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    c_mag     = mag(rd_data_flat[CENTRE*PXL_BITS +: PXL_BITS]);
    lo_e      = (lo_q < hi_q) ? lo_q : hi_q;
    nb_strong = 1'b0;
    for (int unsigned i = 0; i < NWIN; i++) begin
      if (i != CENTRE && mag(rd_data_flat[i*PXL_BITS +: PXL_BITS]) >= hi_q) nb_strong = 1'b1;
    end
    is_edge = (c_mag >= hi_q) || ((c_mag >= lo_e) && nb_strong);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      x1_q      <= '0;
      y1_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_data_q <= '0;
    end else begin
      v1_q    <= rd_en;
      wr_en_q <= v1_q;
      if (rd_en) begin
        x1_q <= cur_x_q;
        y1_q <= cur_y_q;
      end
      if (v1_q) begin
        wr_x_q    <= x1_q;
        wr_y_q    <= y1_q;
        wr_data_q <= is_edge ? {1'b0, MAG_MAX} : '0;
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_x        = wr_x_q;
  assign wr_y        = wr_y_q;
  assign wr_data_pxl = wr_data_q;

`ifdef EDGE_HYST_CNT_EN
  logic [CNT_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == StIdle && run) begin
      cnt_q <= '0;
    end else if (v1_q && is_edge && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign edge_cnt = cnt_q;
`else
  assign edge_cnt = '0;
`endif

endmodule
